// File: rtl/vxc_pkg.sv
// Shared types and elaboration-time helpers for the vxc_axpy_seq vector sequencer.
package vxc_pkg;

   localparam int MAX_UNITS = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DRAIN,
      ST_DONE
   } state_t;

   function automatic int num_chunks(input int num_eq, input int num_units);
      return (num_eq + num_units - 1) / num_units;
   endfunction

   // Lanes of the final chunk that carry real elements; padding lanes stay 0.
   function automatic logic [MAX_UNITS-1:0] last_mask(input int num_eq, input int num_units);
      logic [MAX_UNITS-1:0] m;
      int n;
      n = num_eq - (num_chunks(num_eq, num_units) - 1) * num_units;
      m = '0;
      for (int k = 0; k < MAX_UNITS; k++) begin
         if (k < n) m[k] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/vxc_mac_lane.sv
// vxc_mac_lane: one fixed-point lane computing x*c +/- y with a PIPE_LAT-deep valid/data pipe.
// `define VXC_SAT_EN selects clamping plus a per-result saturation flag instead of wrapping.
module vxc_mac_lane
   import vxc_pkg::*;
#(
   parameter int ELEM_W   = 32,
   parameter int FRAC_W   = 16,
   parameter int PIPE_LAT = 3
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              op,
   input  logic [ELEM_W-1:0] x,
   input  logic [ELEM_W-1:0] y,
   input  logic [ELEM_W-1:0] c,
   output logic              out_valid,
   output logic [ELEM_W-1:0] out_data
`ifdef VXC_SAT_EN
   ,output logic             out_sat
`endif
);

   localparam int PW = 2 * ELEM_W;

   logic signed [PW-1:0] x_w, c_w, prod, p_sh;
   logic signed [PW:0]   p_ext, y_ext, sum;
   logic [ELEM_W-1:0]    res;

   logic [PIPE_LAT-1:0]  vld_q, vld_d;
   logic [ELEM_W-1:0]    data_q [PIPE_LAT];
   logic [ELEM_W-1:0]    data_d [PIPE_LAT];

`ifdef VXC_SAT_EN
   localparam logic signed [PW:0] SAT_MAX = {{(ELEM_W+2){1'b0}}, {(ELEM_W-1){1'b1}}};
   localparam logic signed [PW:0] SAT_MIN = {{(ELEM_W+2){1'b1}}, {(ELEM_W-1){1'b0}}};
   logic                sat;
   logic [PIPE_LAT-1:0] sat_q, sat_d;
`endif

   // The arithmetic is one combinational cloud ahead of the register chain so
   // retiming can spread the multiplier across however many stages PIPE_LAT gives.
   always_comb begin
      // NOTE: every variable here gets a value on every path, so no latch is inferred.
      x_w   = {{ELEM_W{x[ELEM_W-1]}}, x};
      c_w   = {{ELEM_W{c[ELEM_W-1]}}, c};
      prod  = x_w * c_w;
      p_sh  = prod >>> FRAC_W;
      p_ext = {p_sh[PW-1], p_sh};
      y_ext = {{(ELEM_W+1){y[ELEM_W-1]}}, y};
      sum   = op ? (p_ext - y_ext) : (p_ext + y_ext);
`ifdef VXC_SAT_EN
      sat = 1'b0;
      res = ELEM_W'(sum);
      if (sum > SAT_MAX) begin
         sat = 1'b1;
         res = {1'b0, {(ELEM_W-1){1'b1}}};
      end else if (sum < SAT_MIN) begin
         sat = 1'b1;
         res = {1'b1, {(ELEM_W-1){1'b0}}};
      end
`else
      res = ELEM_W'(sum);
`endif
   end

   always_comb begin
      vld_d[0]  = in_valid;
      data_d[0] = in_valid ? res : '0;
`ifdef VXC_SAT_EN
      sat_d[0]  = in_valid & sat;
`endif
      for (int i = 1; i < PIPE_LAT; i++) begin
         vld_d[i]  = vld_q[i-1];
         data_d[i] = data_q[i-1];
`ifdef VXC_SAT_EN
         sat_d[i]  = sat_q[i-1];
`endif
      end
   end

   // NOTE: the data stages are reset as well, because the result bus must read zero
   // out of reset and between writes, not just be qualified by the valid bit.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every stage shifts from pre-edge values.
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < PIPE_LAT; i++) data_q[i] <= '0;
`ifdef VXC_SAT_EN
         sat_q <= '0;
`endif
      end else begin
         vld_q <= vld_d;
         for (int i = 0; i < PIPE_LAT; i++) data_q[i] <= data_d[i];
`ifdef VXC_SAT_EN
         sat_q <= sat_d;
`endif
      end
   end

   assign out_valid = vld_q[PIPE_LAT-1];
   assign out_data  = data_q[PIPE_LAT-1];
`ifdef VXC_SAT_EN
   assign out_sat   = sat_q[PIPE_LAT-1];
`endif

endmodule

// File: rtl/vxc_axpy_seq.sv
// vxc_axpy_seq: fetches x/y chunks, runs NUM_UNITS lanes of x*c +/- y and writes masked result chunks.
// `define VXC_SAT_EN enables saturating lanes and the sticky sat_flag output.
module vxc_axpy_seq
   import vxc_pkg::*;
#(
   parameter int NUM_EQ    = 16,
   parameter int NUM_UNITS = 8,
   parameter int ELEM_W    = 32,
   parameter int FRAC_W    = 16,
   parameter int PIPE_LAT  = 3,
   parameter int AW        = 8
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        op,
   input  logic [ELEM_W-1:0]           constant,
   output logic                        rd_req,
   output logic [AW-1:0]               rd_addr,
   input  logic                        rd_valid,
   input  logic [ELEM_W*NUM_UNITS-1:0] first_row,
   input  logic [ELEM_W*NUM_UNITS-1:0] second_row,
   output logic                        wr_en,
   output logic [AW-1:0]               wr_addr,
   output logic [ELEM_W*NUM_UNITS-1:0] wr_data,
   output logic [NUM_UNITS-1:0]        wr_mask,
   output logic                        busy,
   output logic                        finish
`ifdef VXC_SAT_EN
   ,output logic                       sat_flag
`endif
);

   localparam int                     NUM_CHUNKS    = num_chunks(NUM_EQ, NUM_UNITS);
   localparam logic [MAX_UNITS-1:0]   LAST_MASK_ALL = last_mask(NUM_EQ, NUM_UNITS);
   localparam logic [NUM_UNITS-1:0]   LAST_MASK     = LAST_MASK_ALL[NUM_UNITS-1:0];
   localparam logic [AW-1:0]          LAST_CHUNK    = AW'(NUM_CHUNKS - 1);

   state_t              state_q, state_d;
   logic [AW-1:0]       fetch_q, fetch_d;
   logic                op_q, op_d;
   logic [ELEM_W-1:0]   const_q, const_d;
   logic [AW-1:0]       addr_q [PIPE_LAT];
   logic [AW-1:0]       addr_d [PIPE_LAT];

   logic                start_ok, accept, last_fetch, last_wr;
   logic [NUM_UNITS-1:0] lane_en, lane_vld;

   assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign accept     = (state_q == ST_WAIT) && rd_valid;
   assign last_fetch = (fetch_q == LAST_CHUNK);
   assign lane_en    = last_fetch ? LAST_MASK : '1;

   always_comb begin
      state_d = state_q;
      fetch_d = fetch_q;
      op_d    = op_q;
      const_d = const_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               state_d = ST_REQ;
               fetch_d = '0;
               op_d    = op;
               const_d = constant;
            end
         end
         ST_REQ:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (rd_valid) begin
               fetch_d = fetch_q + 1'b1;
               state_d = last_fetch ? ST_DRAIN : ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (last_wr) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         fetch_q <= '0;
         op_q    <= 1'b0;
         const_q <= '0;
      end else begin
         state_q <= state_d;
         fetch_q <= fetch_d;
         op_q    <= op_d;
         const_q <= const_d;
      end
   end

   // Chunk index travels alongside the lane pipeline so writes carry their own address.
   always_comb begin
      addr_d[0] = accept ? fetch_q : '0;
      for (int i = 1; i < PIPE_LAT; i++) addr_d[i] = addr_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PIPE_LAT; i++) addr_q[i] <= '0;
      end else begin
         for (int i = 0; i < PIPE_LAT; i++) addr_q[i] <= addr_d[i];
      end
   end

`ifdef VXC_SAT_EN
   logic [NUM_UNITS-1:0] lane_sat;
   logic                 sat_q, sat_d;

   always_comb begin
      sat_d = start_ok ? 1'b0 : (sat_q | (|lane_sat));
   end

   always_ff @(posedge clk) begin
      if (reset) sat_q <= 1'b0;
      else       sat_q <= sat_d;
   end

   assign sat_flag = sat_q;
`endif

   for (genvar k = 0; k < NUM_UNITS; k++) begin : g_lane
      vxc_mac_lane #(
         .ELEM_W   (ELEM_W),
         .FRAC_W   (FRAC_W),
         .PIPE_LAT (PIPE_LAT)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (accept & lane_en[k]),
         .op        (op_q),
         .x         (first_row[k*ELEM_W +: ELEM_W]),
         .y         (second_row[k*ELEM_W +: ELEM_W]),
         .c         (const_q),
         .out_valid (lane_vld[k]),
         .out_data  (wr_data[k*ELEM_W +: ELEM_W])
`ifdef VXC_SAT_EN
         ,.out_sat  (lane_sat[k])
`endif
      );
   end

   // Lane 0 is valid in every chunk, so any valid lane marks a write.
   assign wr_en   = |lane_vld;
   assign wr_mask = lane_vld;
   assign wr_addr = addr_q[PIPE_LAT-1];
   assign last_wr = wr_en && (wr_addr == LAST_CHUNK);

   assign rd_req  = (state_q == ST_REQ);
   assign rd_addr = fetch_q;
   assign busy    = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_DRAIN);
   assign finish  = (state_q == ST_DONE);

endmodule
